// File: rtl/pgm_pkg.sv
// Shared constants and state encodings for the PGM write side.
// Opcodes, word header codes and FSM enums used by pgm_wr and pgm_wr_ctl.
package pgm_pkg;

    localparam logic [3:0] OpStore  = 4'd1;
    localparam logic [3:0] OpStart  = 4'd2;
    localparam logic [3:0] OpFinish = 4'd3;
    localparam logic [3:0] OpClear  = 4'd4;

    localparam logic [1:0] HdrHead = 2'b01;
    localparam logic [1:0] HdrMid  = 2'b11;
    localparam logic [1:0] HdrTail = 2'b10;

    localparam int unsigned DataW  = 134;
    localparam int unsigned PhvW   = 1024;
    localparam int unsigned RamDw  = 144;

    typedef enum logic [1:0] {PktIdle, PktPass, PktStore, PktDrop} pkt_state_e;
    typedef enum logic [1:0] {GenEmpty, GenLoaded, GenRun, GenFin} gen_state_e;

endpackage

// File: rtl/pgm_wr_ctl.sv
// Generator state machine for the PGM write side: tracks RAM contents and
// drives the bypass/start/finish flags plus stored length and overflow error.
module pgm_wr_ctl
    import pgm_pkg::*;
#(
    parameter int unsigned RAM_AW = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_store_done,
    input  logic              i_store_ovf,
    input  logic [RAM_AW:0]   i_store_len,
    input  logic              i_start,
    input  logic              i_finish,
    input  logic              i_clear,
    output logic              o_store_ok,
    output logic              o_bypass,
    output logic              o_start,
    output logic              o_finish,
    output logic [RAM_AW:0]   o_len,
    output logic              o_err
);

    gen_state_e      r_gen;
    gen_state_e      w_gen_nxt;
    logic [RAM_AW:0] r_len;
    logic            r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen <= GenEmpty;
        end else begin
            r_gen <= w_gen_nxt;
        end
    end

    always_comb begin
        w_gen_nxt = r_gen;
        if (i_clear) begin
            w_gen_nxt = GenEmpty;
        end else begin
            unique case (r_gen)
                GenEmpty:  if (i_store_done) w_gen_nxt = GenLoaded;
                GenLoaded: begin
                    if (i_store_done) begin
                        w_gen_nxt = GenLoaded;
                    end else if (i_start) begin
                        w_gen_nxt = GenRun;
                    end
                end
                GenRun:    if (i_finish) w_gen_nxt = GenFin;
                GenFin:    w_gen_nxt = GenFin;
                default:   w_gen_nxt = GenEmpty;
            endcase
        end
    end

    always_comb begin
        o_store_ok = (r_gen == GenEmpty) || (r_gen == GenLoaded);
        o_bypass   = (r_gen != GenRun);
        o_start    = (r_gen == GenRun);
        o_finish   = (r_gen == GenFin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_err <= 1'b0;
        end else if (i_clear) begin
            r_len <= '0;
            r_err <= 1'b0;
        end else if (i_store_done) begin
            r_len <= i_store_len;
            r_err <= i_store_ovf;
        end
    end

    assign o_len = r_len;
    assign o_err = r_err;

endmodule

// File: rtl/pgm_wr.sv
// PGM write side: forwards normal packets with one cycle of latency and absorbs
// PGM control packets, writing STORE bodies into PGM_RAM.
module pgm_wr
    import pgm_pkg::*;
#(
    parameter string       PLATFORM = "Xilinx",
    parameter int unsigned RAM_AW   = 7,
    parameter logic [3:0]  PGM_TAG  = 4'hA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PhvW-1:0]      in_wr_phv,
    input  logic                 in_wr_phv_wr,
    output logic                 out_wr_phv_alf,
    input  logic [DataW-1:0]     in_wr_data,
    input  logic                 in_wr_data_wr,
    input  logic                 in_wr_valid,
    input  logic                 in_wr_valid_wr,
    output logic                 out_wr_alf,
    output logic [PhvW-1:0]      out_wr_phv,
    output logic                 out_wr_phv_wr,
    input  logic                 in_wr_phv_alf,
    output logic [DataW-1:0]     out_wr_data,
    output logic                 out_wr_data_wr,
    output logic                 out_wr_valid,
    output logic                 out_wr_valid_wr,
    input  logic                 in_wr_alf,
    output logic                 wr2ram_wr,
    output logic [RAM_AW-1:0]    wr2ram_addr,
    output logic [RamDw-1:0]     wr2ram_wdata,
    output logic                 pgm_bypass_flag,
    output logic                 pgm_sent_start_flag,
    output logic                 pgm_sent_finish_flag,
    output logic [RAM_AW:0]      pgm_pkt_len,
    output logic                 pgm_store_err
);

    localparam int unsigned     Depth    = 2 ** RAM_AW;
    localparam logic [RAM_AW:0] LenFull  = (RAM_AW + 1)'(Depth);
    localparam logic [RAM_AW:0] LastAddr = (RAM_AW + 1)'(Depth - 1);

    pkt_state_e          r_state;
    pkt_state_e          w_state_nxt;
    logic [3:0]          r_op;
    logic [RAM_AW:0]     r_cnt;
    logic                r_ovf;

    logic                w_head;
    logic                w_tail;
    logic                w_is_pgm;
    logic [3:0]          w_op;
    logic                w_store_ok;
    logic                w_accept;
    logic                w_fwd;
    logic                w_ram_we;
    logic                w_ram_first;
    logic                w_ovf_word;
    logic                w_store_end;
    logic                w_op_tail;
    logic [RAM_AW:0]     w_store_len;
    logic [DataW-1:0]    w_ram_word;

    logic                r_phv_wr;
    logic [PhvW-1:0]     r_phv;
    logic                r_data_wr;
    logic [DataW-1:0]    r_data;
    logic                r_valid_wr;
    logic                r_valid;
    logic                r_ram_wr;
    logic [RAM_AW-1:0]   r_ram_addr;
    logic [DataW-1:0]    r_ram_wdata;

    assign w_head   = in_wr_data_wr && (in_wr_data[133:132] == HdrHead);
    assign w_tail   = in_wr_data_wr && (in_wr_data[133:132] == HdrTail);
    assign w_is_pgm = (in_wr_phv[1023:1020] == PGM_TAG);
    assign w_op     = in_wr_phv[1019:1016];
    assign w_accept = w_head && w_is_pgm && (w_op == OpStore) && w_store_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PktIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            PktIdle: begin
                if (w_head) begin
                    if (!w_is_pgm) begin
                        w_state_nxt = PktPass;
                    end else if (w_accept) begin
                        w_state_nxt = PktStore;
                    end else begin
                        w_state_nxt = PktDrop;
                    end
                end
            end
            PktPass, PktStore, PktDrop: if (w_tail) w_state_nxt = PktIdle;
            default: w_state_nxt = PktIdle;
        endcase
    end

    always_comb begin
        w_fwd       = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_first = 1'b0;
        w_ovf_word  = 1'b0;
        w_store_end = 1'b0;
        w_op_tail   = 1'b0;
        unique case (r_state)
            PktIdle: begin
                w_fwd       = w_head && !w_is_pgm;
                w_ram_we    = w_accept;
                w_ram_first = w_accept;
            end
            PktPass: w_fwd = 1'b1;
            PktStore: begin
                // Once the last address is used, words are dropped until the tail
                w_ram_we    = in_wr_data_wr && (r_cnt != LenFull);
                w_ovf_word  = w_ram_we && (r_cnt == LastAddr) && !w_tail;
                w_store_end = w_tail;
            end
            PktDrop: w_op_tail = w_tail;
            default: ;
        endcase
    end

    always_comb begin
        w_ram_word = in_wr_data;
        if (w_ovf_word) begin
            w_ram_word[133:132] = HdrTail;
        end
        w_store_len = w_ram_we ? r_cnt + 1'b1 : r_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (r_state == PktIdle && w_head && w_is_pgm) begin
                r_op <= w_op;
            end
            if (w_ram_first) begin
                r_cnt <= (RAM_AW + 1)'(1);
                r_ovf <= 1'b0;
            end else if (w_ram_we) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_ovf_word) r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phv_wr    <= 1'b0;
            r_phv       <= '0;
            r_data_wr   <= 1'b0;
            r_data      <= '0;
            r_valid_wr  <= 1'b0;
            r_valid     <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_phv_wr   <= in_wr_phv_wr && w_fwd;
            r_data_wr  <= in_wr_data_wr && w_fwd;
            r_valid_wr <= in_wr_valid_wr && w_fwd;
            r_ram_wr   <= w_ram_we;
            if (in_wr_phv_wr && w_fwd)   r_phv   <= in_wr_phv;
            if (in_wr_data_wr && w_fwd)  r_data  <= in_wr_data;
            if (in_wr_valid_wr && w_fwd) r_valid <= in_wr_valid;
            if (w_ram_we) begin
                r_ram_addr  <= w_ram_first ? '0 : r_cnt[RAM_AW-1:0];
                r_ram_wdata <= w_ram_word;
            end
        end
    end

    pgm_wr_ctl #(
        .RAM_AW (RAM_AW)
    ) u_ctl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_store_done (w_store_end),
        .i_store_ovf  (r_ovf),
        .i_store_len  (w_store_len),
        .i_start      (w_op_tail && (r_op == OpStart)),
        .i_finish     (w_op_tail && (r_op == OpFinish)),
        .i_clear      (w_op_tail && (r_op == OpClear)),
        .o_store_ok   (w_store_ok),
        .o_bypass     (pgm_bypass_flag),
        .o_start      (pgm_sent_start_flag),
        .o_finish     (pgm_sent_finish_flag),
        .o_len        (pgm_pkt_len),
        .o_err        (pgm_store_err)
    );

    // Vendor hook: every target currently passes almost-full straight through
    if (PLATFORM == "Xilinx") begin : g_alf_xilinx
        assign out_wr_phv_alf = in_wr_phv_alf;
        assign out_wr_alf     = in_wr_alf;
    end else begin : g_alf_generic
        assign out_wr_phv_alf = in_wr_phv_alf;
        assign out_wr_alf     = in_wr_alf;
    end

    assign out_wr_phv      = r_phv;
    assign out_wr_phv_wr   = r_phv_wr;
    assign out_wr_data     = r_data;
    assign out_wr_data_wr  = r_data_wr;
    assign out_wr_valid    = r_valid;
    assign out_wr_valid_wr = r_valid_wr;
    assign wr2ram_wr       = r_ram_wr;
    assign wr2ram_addr     = r_ram_addr;
    assign wr2ram_wdata    = {10'b0, r_ram_wdata};

endmodule

// File: tb/tb_pgm_wr.sv
// Directed bench for pgm_wr: forwarding, STORE/START/FINISH/CLEAR sequencing,
// RAM overflow and mid-packet reset.
module tb_pgm_wr;

    logic            clk;
    logic            rst_n;
    logic [1023:0]   in_wr_phv;
    logic            in_wr_phv_wr;
    logic            out_wr_phv_alf;
    logic [133:0]    in_wr_data;
    logic            in_wr_data_wr;
    logic            in_wr_valid;
    logic            in_wr_valid_wr;
    logic            out_wr_alf;
    logic [1023:0]   out_wr_phv;
    logic            out_wr_phv_wr;
    logic            in_wr_phv_alf;
    logic [133:0]    out_wr_data;
    logic            out_wr_data_wr;
    logic            out_wr_valid;
    logic            out_wr_valid_wr;
    logic            in_wr_alf;
    logic            wr2ram_wr;
    logic [6:0]      wr2ram_addr;
    logic [143:0]    wr2ram_wdata;
    logic            pgm_bypass_flag;
    logic            pgm_sent_start_flag;
    logic            pgm_sent_finish_flag;
    logic [7:0]      pgm_pkt_len;
    logic            pgm_store_err;

    int              n_checks;
    int              n_errors;
    int              n_ram_wr;
    logic            ram_hi_nz;
    logic [133:0]    ram_m [128];
    logic [133:0]    fwd_q [$];
    logic [133:0]    w_exp;

    pgm_wr u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_wr_phv            (in_wr_phv),
        .in_wr_phv_wr         (in_wr_phv_wr),
        .out_wr_phv_alf       (out_wr_phv_alf),
        .in_wr_data           (in_wr_data),
        .in_wr_data_wr        (in_wr_data_wr),
        .in_wr_valid          (in_wr_valid),
        .in_wr_valid_wr       (in_wr_valid_wr),
        .out_wr_alf           (out_wr_alf),
        .out_wr_phv           (out_wr_phv),
        .out_wr_phv_wr        (out_wr_phv_wr),
        .in_wr_phv_alf        (in_wr_phv_alf),
        .out_wr_data          (out_wr_data),
        .out_wr_data_wr       (out_wr_data_wr),
        .out_wr_valid         (out_wr_valid),
        .out_wr_valid_wr      (out_wr_valid_wr),
        .in_wr_alf            (in_wr_alf),
        .wr2ram_wr            (wr2ram_wr),
        .wr2ram_addr          (wr2ram_addr),
        .wr2ram_wdata         (wr2ram_wdata),
        .pgm_bypass_flag      (pgm_bypass_flag),
        .pgm_sent_start_flag  (pgm_sent_start_flag),
        .pgm_sent_finish_flag (pgm_sent_finish_flag),
        .pgm_pkt_len          (pgm_pkt_len),
        .pgm_store_err        (pgm_store_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record RAM writes and forwarded words away from the active edge
    always @(negedge clk) begin
        if (wr2ram_wr) begin
            ram_m[wr2ram_addr] = wr2ram_wdata[133:0];
            n_ram_wr++;
            if (wr2ram_wdata[143:134] != 10'b0) ram_hi_nz = 1'b1;
        end
        if (out_wr_data_wr) fwd_q.push_back(out_wr_data);
    end

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [133:0] mk_word(input int i, input int n, input logic [31:0] base);
        logic [1:0] hdr;
        hdr = (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b11;
        return {hdr, 100'h0, base + 32'(i)};
    endfunction

    task automatic drive_word(input logic [3:0] tag, input logic [3:0] op, input int i,
                              input int n, input logic [31:0] base);
        in_wr_data_wr  = 1'b1;
        in_wr_data     = mk_word(i, n, base);
        in_wr_phv_wr   = (i == 0);
        in_wr_phv      = {tag, op, 984'h0, base};
        in_wr_valid_wr = (i == n - 1);
        in_wr_valid    = (i == n - 1);
    endtask

    task automatic idle_inputs();
        in_wr_data_wr  = 1'b0;
        in_wr_phv_wr   = 1'b0;
        in_wr_valid_wr = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] tag, input logic [3:0] op, input int n,
                            input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_word(tag, op, i, n, base);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_ram_wr  = 0;
        ram_hi_nz = 1'b0;
        rst_n     = 1'b0;
        in_wr_phv = '0;
        in_wr_data = '0;
        in_wr_valid = 1'b0;
        in_wr_phv_alf = 1'b0;
        in_wr_alf = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);

        check("rst_bypass", pgm_bypass_flag, 1);
        check("rst_start", pgm_sent_start_flag, 0);
        check("rst_finish", pgm_sent_finish_flag, 0);
        check("rst_len", pgm_pkt_len, 0);
        check("rst_err", pgm_store_err, 0);
        check("rst_ram_wr", wr2ram_wr, 0);
        check("rst_out_wr", out_wr_data_wr, 0);
        rst_n = 1'b1;

        // Normal packet: each word appears one cycle later
        in_wr_alf = 1'b1;
        in_wr_phv_alf = 1'b1;
        #1;
        check("alf_pass", out_wr_alf, 1);
        check("phv_alf_pass", out_wr_phv_alf, 1);
        in_wr_alf = 1'b0;
        in_wr_phv_alf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_word(4'h0, 4'h1, i, 4, 32'h50);
            @(posedge clk);
            #1;
            w_exp = mk_word(i, 4, 32'h50);
            check("fwd_wr", out_wr_data_wr, 1);
            check("fwd_data", out_wr_data, w_exp);
            if (i == 0) begin
                check("fwd_phv_wr", out_wr_phv_wr, 1);
                check("fwd_phv_lo", out_wr_phv[31:0], 32'h50);
            end
            if (i == 3) check("fwd_valid_wr", out_wr_valid_wr, 1);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("t1_no_ram", n_ram_wr, 0);
        check("t1_bypass", pgm_bypass_flag, 1);

        // STORE 3 words then START
        fwd_q.delete();
        send_pkt(4'hA, 4'd1, 3, 32'h100);
        check("t2_nwr", n_ram_wr, 3);
        check("t2_ram0", ram_m[0], mk_word(0, 3, 32'h100));
        check("t2_ram1", ram_m[1], mk_word(1, 3, 32'h100));
        check("t2_ram2", ram_m[2], mk_word(2, 3, 32'h100));
        check("t2_len", pgm_pkt_len, 3);
        check("t2_err", pgm_store_err, 0);
        check("t2_bypass_loaded", pgm_bypass_flag, 1);
        check("t2_no_fwd", fwd_q.size(), 0);
        send_pkt(4'hA, 4'd2, 2, 32'h0);
        check("t2_start", pgm_sent_start_flag, 1);
        check("t2_bypass", pgm_bypass_flag, 0);
        check("t2_finish", pgm_sent_finish_flag, 0);

        // STORE while RUN is dropped; FINISH; CLEAR
        n_ram_wr = 0;
        send_pkt(4'hA, 4'd1, 3, 32'h200);
        check("t4_nwr", n_ram_wr, 0);
        check("t4_len", pgm_pkt_len, 3);
        check("t4_ram0", ram_m[0], mk_word(0, 3, 32'h100));
        send_pkt(4'hA, 4'd3, 2, 32'h0);
        check("t4_finish", pgm_sent_finish_flag, 1);
        check("t4_start", pgm_sent_start_flag, 0);
        check("t4_bypass_fin", pgm_bypass_flag, 1);
        send_pkt(4'hA, 4'd4, 2, 32'h0);
        check("t4_clr_bypass", pgm_bypass_flag, 1);
        check("t4_clr_finish", pgm_sent_finish_flag, 0);
        check("t4_clr_len", pgm_pkt_len, 0);

        // START while EMPTY, FINISH while LOADED, unknown opcode
        send_pkt(4'hA, 4'd2, 2, 32'h0);
        check("t5_start_empty", pgm_sent_start_flag, 0);
        check("t5_bypass_empty", pgm_bypass_flag, 1);
        send_pkt(4'hA, 4'd1, 2, 32'h300);
        check("t5_len", pgm_pkt_len, 2);
        send_pkt(4'hA, 4'd3, 2, 32'h0);
        check("t5_fin_loaded", pgm_sent_finish_flag, 0);
        check("t5_start_loaded", pgm_sent_start_flag, 0);
        send_pkt(4'hA, 4'd7, 2, 32'h0);
        check("t5_unknown_len", pgm_pkt_len, 2);
        send_pkt(4'hA, 4'd2, 2, 32'h0);
        check("t5_start_after", pgm_sent_start_flag, 1);
        send_pkt(4'hA, 4'd4, 2, 32'h0);
        check("t5_clear", pgm_sent_start_flag, 0);

        // Exactly full store: no overflow
        n_ram_wr = 0;
        send_pkt(4'hA, 4'd1, 128, 32'h800);
        check("t3_full_nwr", n_ram_wr, 128);
        check("t3_full_len", pgm_pkt_len, 128);
        check("t3_full_err", pgm_store_err, 0);
        check("t3_full_last", ram_m[127], mk_word(127, 128, 32'h800));

        // Overflow store
        n_ram_wr = 0;
        send_pkt(4'hA, 4'd1, 130, 32'h1000);
        check("t3_nwr", n_ram_wr, 128);
        check("t3_ram126", ram_m[126], mk_word(126, 130, 32'h1000));
        w_exp = mk_word(127, 130, 32'h1000);
        w_exp[133:132] = 2'b10;
        check("t3_ram127", ram_m[127], w_exp);
        check("t3_err", pgm_store_err, 1);
        check("t3_len", pgm_pkt_len, 128);
        check("t3_hi_zero", ram_hi_nz, 0);
        fwd_q.delete();
        send_pkt(4'h0, 4'd0, 3, 32'h60);
        check("t3_pass_n", fwd_q.size(), 3);
        if (fwd_q.size() > 0) check("t3_pass_w0", fwd_q[0], mk_word(0, 3, 32'h60));
        send_pkt(4'hA, 4'd1, 4, 32'h400);
        check("t3_err_clr", pgm_store_err, 0);
        check("t3_len4", pgm_pkt_len, 4);

        // Reset in the middle of a STORE
        @(negedge clk);
        drive_word(4'hA, 4'd1, 0, 4, 32'h500);
        @(negedge clk);
        drive_word(4'hA, 4'd1, 1, 4, 32'h500);
        rst_n = 1'b0;
        #1;
        check("t6_ram_wr", wr2ram_wr, 0);
        check("t6_len", pgm_pkt_len, 0);
        check("t6_bypass", pgm_bypass_flag, 1);
        check("t6_out_wr", out_wr_data_wr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_ram_wr = 0;
        fwd_q.delete();
        drive_word(4'hA, 4'd1, 2, 4, 32'h500);
        @(negedge clk);
        drive_word(4'hA, 4'd1, 3, 4, 32'h500);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("t6_ignored_wr", n_ram_wr, 0);
        check("t6_ignored_fwd", fwd_q.size(), 0);
        check("t6_len_after", pgm_pkt_len, 0);
        send_pkt(4'h0, 4'd0, 2, 32'h70);
        check("t6_pass_n", fwd_q.size(), 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
